// File: rtl/ff_reg_write_arbiter_if.sv
// Bus bundle between the producer side and the shared-register write arbiter.
// Groups request/data inputs and register/acknowledge outputs into one port.
//
// Handshake: a producer raises req[i] with data lane i and holds both stable
// until it sees ack[i]. ack[i] is a one-cycle pulse meaning lane i was written
// into q at the edge that raised ack. The producer may drop req[i] in the ack
// cycle. A req still high in that cycle is simply re-arbitrated.
interface ff_reg_write_arbiter_if #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [W-1:0]   q;
    logic [N-1:0]   ack;
    logic           upd;
    logic [SELW-1:0] src;
    logic [7:0]     wr_cnt;

    // Producer side: drives requests and data, observes the register.
    modport master (
        output req,
        output data,
        input  q,
        input  ack,
        input  upd,
        input  src,
        input  wr_cnt
    );

    // Arbiter side: consumes requests and data, owns the register.
    modport slave (
        input  req,
        input  data,
        output q,
        output ack,
        output upd,
        output src,
        output wr_cnt
    );
endinterface

// File: rtl/ff_reg_write_arbiter.sv
// Round-robin write arbiter for one shared W-bit register.
// Each rising edge writes at most one requester's data lane into q. The
// winner is acked for one cycle and its index is kept in src.
// Optional feature: define FF_ARB_RELOAD_EN to add a 'reload' input that
// restores q to INIT at a clock edge, taking priority over requests.
module ff_reg_write_arbiter #(
    parameter int          N    = 4,
    parameter int          W    = 8,
    parameter logic [W-1:0] INIT = {W{1'b0}}
) (
    input  logic clk,
    input  logic rst_n,
`ifdef FF_ARB_RELOAD_EN
    input  logic reload,
`endif
    ff_reg_write_arbiter_if.slave bus
);
    localparam int SELW = $clog2(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    // Register state.
    logic [W-1:0]    q_r;
    logic [N-1:0]    ack_r;
    logic            upd_r;
    logic [SELW-1:0] src_r;
    logic [7:0]      wr_cnt_r;
    // Index of the last winner. The search starts just after it.
    logic [SELW-1:0] last;

    // Arbitration result for the current cycle.
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [W-1:0]    grant_data;

    // Round-robin search: last+1, last+2, ... wrapping, ending at last.
    // The first asserted request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last;
        for (int k = 1; k <= N; k++) begin
            if (!grant_valid && bus.req[(int'(last) + k) % N]) begin
                grant_valid = 1'b1;
                grant_idx   = SELW'((int'(last) + k) % N);
            end
        end
    end

    // Only the winning lane reaches q. Other lanes, even X, are not selected.
    assign grant_data = bus.data[int'(grant_idx) * W +: W];

    // Register update, acknowledge pulse, pointer and saturating write count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r      <= INIT;
            ack_r    <= '0;
            upd_r    <= 1'b0;
            src_r    <= '0;
            wr_cnt_r <= 8'd0;
            last     <= SELW'(N - 1);
        end
`ifdef FF_ARB_RELOAD_EN
        else if (reload) begin
            // Reload wins over requests. Blocked requesters retry next cycle.
            q_r   <= INIT;
            ack_r <= '0;
            upd_r <= 1'b1;
        end
`endif
        else if (grant_valid) begin
            q_r   <= grant_data;
            ack_r <= ONE_N << grant_idx;
            upd_r <= 1'b1;
            src_r <= grant_idx;
            last  <= grant_idx;
            if (wr_cnt_r != 8'hFF) begin
                wr_cnt_r <= wr_cnt_r + 8'd1;
            end
        end else begin
            ack_r <= '0;
            upd_r <= 1'b0;
        end
    end

    assign bus.q      = q_r;
    assign bus.ack    = ack_r;
    assign bus.upd    = upd_r;
    assign bus.src    = src_r;
    assign bus.wr_cnt = wr_cnt_r;

endmodule
